register_dump_reader: RTL and testbench
=======================================

REGISTER_DUMP_READER -- requirements
Module: register_dump_reader

Interface
REQ-001 SHALL have parameter START_INDEX, default 0: first register index dumped.
REQ-002 SHALL have parameter END_INDEX, default 31: last register index dumped; START_INDEX <= END_INDEX <= 31 is required, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port start  input  1  single-cycle dump request.
REQ-006 SHALL have port readRegister  output  5  index driven to the register file read port.
REQ-007 SHALL have port readData  input  32  register file read data; combinational from readRegister within the same cycle.
REQ-008 SHALL have port dumpValid  output  1  dump beat valid.
REQ-009 SHALL have port dumpReady  input  1  consumer accepts the beat.
REQ-010 SHALL have port dumpIndex  output  5  register index of the current beat.
REQ-011 SHALL have port dumpData  output  32  register value of the current beat.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, SEND, DONE, with state, index counter and all outputs registered.
REQ-015 IDLE: start=1 at posedge -> FETCH with idx=START_INDEX; otherwise stay in IDLE.
REQ-016 FETCH: readRegister=idx; at posedge, capture dumpData<=readData and dumpIndex<=idx, then go to SEND; FETCH lasts exactly 1 cycle.
REQ-017 SEND: dumpValid=1; while dumpReady=0, hold state, dumpValid, dumpData and dumpIndex unchanged.
REQ-018 SEND, beat accepted (dumpValid&dumpReady at posedge) with idx==END_INDEX -> DONE.
REQ-019 SEND, beat accepted with idx!=END_INDEX -> idx+1, go to FETCH; idx never wraps past END_INDEX.
REQ-020 DONE: done=1 for exactly 1 cycle, then IDLE.
REQ-021 dumpValid SHALL be 1 only in SEND; done SHALL be 1 only in DONE.
REQ-022 readRegister SHALL equal idx in FETCH and SEND, and 0 in IDLE and DONE.
REQ-023 Latency: start accepted at edge 0 -> first dumpValid in cycle 2; with dumpReady held at 1, each beat takes 2 cycles.
REQ-024 start SHALL be ignored in FETCH, SEND and DONE, with no queuing; start in the DONE cycle is dropped.
REQ-025 Snapshot semantics: a register written after its FETCH cycle SHALL NOT alter the beat already captured.
REQ-026 dumpReady asserted outside SEND SHALL have no effect.
REQ-027 START_INDEX==END_INDEX SHALL produce exactly one beat followed by done.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for clk, set state=IDLE, idx=0, dumpValid=0, done=0, dumpData=0, dumpIndex=0, readRegister=0.
REQ-029 reset asserted mid-dump SHALL abort the dump with no done pulse; a later start SHALL restart from START_INDEX.
REQ-030 The first posedge after reset deassertion SHALL sample start normally.

Verification
REQ-031 Full dump: defaults, register r=r*0x01010101, start pulse, dumpReady=1 -> 32 beats, dumpIndex 0..31, data r*0x01010101, beat k valid in cycle 2+2k, done in cycle 65.
REQ-032 Backpressure: dumpReady=0 for 5 cycles on beat 3 -> dumpValid held with dumpIndex=3 and dumpData stable; done delayed by 5 cycles.
REQ-033 Snapshot: write r4=0xDEADBEEF in the cycle after beat 4's FETCH -> beat 4 shows the old value; a second dump shows 0xDEADBEEF.
REQ-034 Ignored start: pulse start during SEND of beat 10 and during DONE -> exactly one dump, one done pulse.
REQ-035 Async reset: drive reset low mid-cycle during SEND of beat 7 -> dumpValid=0 and busy=0 before the next edge, no done pulse; restart produces beats from index 0.
REQ-036 Params START_INDEX=5, END_INDEX=5 -> one beat (index 5), done in cycle 3.

Source files
------------

// File: rtl/register_dump_reader.sv
// register_dump_reader: walks register indices START_INDEX..END_INDEX through a
// combinational register-file read port and streams each value as a valid/ready beat.
module register_dump_reader #(
   parameter int START_INDEX = 0,
   parameter int END_INDEX   = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [4:0]  readRegister,
   input  logic [31:0] readData,
   output logic        dumpValid,
   input  logic        dumpReady,
   output logic [4:0]  dumpIndex,
   output logic [31:0] dumpData,
   output logic        busy,
   output logic        done
);
   if (START_INDEX < 0 || START_INDEX > END_INDEX || END_INDEX > 31) begin : g_bad_range
      $error("register_dump_reader: need 0 <= START_INDEX <= END_INDEX <= 31");
   end
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam logic [4:0] START_IDX = 5'(START_INDEX);
   localparam logic [4:0] END_IDX   = 5'(END_INDEX);
   logic [1:0]  state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [4:0]  rreg_q, rreg_d;
   logic [4:0]  dindex_q, dindex_d;
   logic [31:0] ddata_q, ddata_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        accept;
   assign accept = (state_q == SEND) && dumpReady;
   always_comb begin
      state_d  = state_q == IDLE  ? (start ? FETCH : IDLE) :
                 state_q == FETCH ? SEND :
                 state_q == SEND  ? (dumpReady ? (idx_q == END_IDX ? DONE : FETCH) : SEND) :
                 IDLE;
      idx_d    = (state_q == IDLE && start) ? START_IDX :
                 (accept && idx_q != END_IDX) ? idx_q + 5'd1 : idx_q;
      // Outputs are registered, so they are computed from the next state.
      rreg_d   = (state_d == FETCH || state_d == SEND) ? idx_d : 5'd0;
      ddata_d  = state_q == FETCH ? readData : ddata_q;
      dindex_d = state_q == FETCH ? idx_q : dindex_q;
      valid_d  = state_d == SEND;
      busy_d   = state_d != IDLE;
      done_d   = state_d == DONE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= 5'd0;
         rreg_q   <= 5'd0;
         ddata_q  <= 32'd0;
         dindex_q <= 5'd0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rreg_q   <= rreg_d;
         ddata_q  <= ddata_d;
         dindex_q <= dindex_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end
   assign readRegister = rreg_q;
   assign dumpData     = ddata_q;
   assign dumpIndex    = dindex_q;
   assign dumpValid    = valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
endmodule

// File: tb/tb_register_dump_reader.sv
// tb_register_dump_reader: directed checks of the dump reader against closed-form
// beat timing, with a behavioral register file on the read port.
module tb_register_dump_reader;
   logic        clk, reset, start, dumpReady;
   logic [4:0]  readRegister, dumpIndex;
   logic [31:0] readData, dumpData;
   logic        dumpValid, busy, done;
   logic        start5, ready5;
   logic [4:0]  rr5, idx5;
   logic [31:0] rd5, data5;
   logic        valid5, busy5, done5;
   logic [31:0] regs [32];
   int checks = 0;
   int failures = 0;

   register_dump_reader dut (
      .clk(clk), .reset(reset), .start(start), .readRegister(readRegister),
      .readData(readData), .dumpValid(dumpValid), .dumpReady(dumpReady),
      .dumpIndex(dumpIndex), .dumpData(dumpData), .busy(busy), .done(done)
   );
   register_dump_reader #(.START_INDEX(5), .END_INDEX(5)) dut5 (
      .clk(clk), .reset(reset), .start(start5), .readRegister(rr5),
      .readData(rd5), .dumpValid(valid5), .dumpReady(ready5),
      .dumpIndex(idx5), .dumpData(data5), .busy(busy5), .done(done5)
   );
   assign readData = regs[readRegister];
   assign rd5      = regs[rr5];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // sb/sl: stall beat and stall length; wr_c: cycle r4 is overwritten;
   // ign: pulse start during beat 10 and DONE; rst_c: cycle reset is asserted mid-cycle.
   task automatic run_dump(input string name, input int sb, input int sl, input int wr_c,
                           input logic [31:0] exp4, input bit ign, input int rst_c);
      int dc, dones, vs, ve;
      logic ev;
      logic [4:0] ek;
      logic [31:0] ed;
      dc = 65 + (sb >= 0 ? sl : 0);
      dones = 0;
      dumpReady = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= dc + 3; c++) begin
         ev = 1'b0;
         ek = 5'd0;
         for (int k = 0; k < 32; k++) begin
            vs = 2 + 2 * k + ((sb >= 0 && k > sb) ? sl : 0);
            ve = vs + (k == sb ? sl : 0);
            if (c >= vs && c <= ve) begin
               ev = 1'b1;
               ek = 5'(k);
            end
         end
         ed = (ek == 5'd4) ? exp4 : 32'(ek) * 32'h01010101;
         chk($sformatf("%s c%0d valid", name, c), 32'(dumpValid), 32'(ev));
         chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == dc));
         chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c <= dc));
         if (ev) begin
            chk($sformatf("%s c%0d index", name, c), 32'(dumpIndex), 32'(ek));
            chk($sformatf("%s c%0d data", name, c), dumpData, ed);
            chk($sformatf("%s c%0d readRegister", name, c), 32'(readRegister), 32'(ek));
         end
         if (done) dones++;
         if (c == rst_c) begin
            #2 reset = 1'b0;
            #1;
            chk($sformatf("%s async valid", name), 32'(dumpValid), 32'd0);
            chk($sformatf("%s async busy", name), 32'(busy), 32'd0);
            chk($sformatf("%s async done", name), 32'(done), 32'd0);
            chk($sformatf("%s async index", name), 32'(dumpIndex), 32'd0);
            chk($sformatf("%s async data", name), dumpData, 32'd0);
            chk($sformatf("%s async readRegister", name), 32'(readRegister), 32'd0);
            for (int i = 0; i < 3; i++) begin
               tick();
               chk($sformatf("%s held done %0d", name, i), 32'(done), 32'd0);
               chk($sformatf("%s held busy %0d", name, i), 32'(busy), 32'd0);
            end
            #2 reset = 1'b1;
            return;
         end
         dumpReady = !(ev && ek == 5'(sb) && c < 2 + 2 * sb + sl);
         start = ign && (c == 22 || c == dc);
         if (c == wr_c) regs[4] = 32'hDEADBEEF;
         tick();
      end
      start = 1'b0;
      dumpReady = 1'b1;
      chk($sformatf("%s done pulses", name), 32'(dones), 32'd1);
   endtask

   initial begin
      for (int r = 0; r < 32; r++) regs[r] = 32'(r) * 32'h01010101;
      reset = 1'b0;
      start = 1'b0;
      dumpReady = 1'b1;
      start5 = 1'b0;
      ready5 = 1'b1;
      #1;
      chk("reset valid", 32'(dumpValid), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset data", dumpData, 32'd0);
      chk("reset index", 32'(dumpIndex), 32'd0);
      chk("reset readRegister", 32'(readRegister), 32'd0);
      #20 reset = 1'b1;
      tick();
      chk("idle busy", 32'(busy), 32'd0);
      run_dump("full", -1, 0, -1, 32'h04040404, 1'b0, -1);
      run_dump("stall", 3, 5, -1, 32'h04040404, 1'b0, -1);
      run_dump("snap1", -1, 0, 10, 32'h04040404, 1'b0, -1);
      run_dump("snap2", -1, 0, -1, 32'hDEADBEEF, 1'b0, -1);
      run_dump("ignore", -1, 0, -1, 32'hDEADBEEF, 1'b1, -1);
      run_dump("abort", -1, 0, -1, 32'hDEADBEEF, 1'b0, 16);
      run_dump("restart", -1, 0, -1, 32'hDEADBEEF, 1'b0, -1);
      start5 = 1'b1;
      tick();
      start5 = 1'b0;
      chk("p5 c1 busy", 32'(busy5), 32'd1);
      chk("p5 c1 valid", 32'(valid5), 32'd0);
      chk("p5 c1 readRegister", 32'(rr5), 32'd5);
      tick();
      chk("p5 c2 valid", 32'(valid5), 32'd1);
      chk("p5 c2 index", 32'(idx5), 32'd5);
      chk("p5 c2 data", data5, 32'h05050505);
      tick();
      chk("p5 c3 valid", 32'(valid5), 32'd0);
      chk("p5 c3 done", 32'(done5), 32'd1);
      chk("p5 c3 readRegister", 32'(rr5), 32'd0);
      tick();
      chk("p5 c4 done", 32'(done5), 32'd0);
      chk("p5 c4 busy", 32'(busy5), 32'd0);
      chk("p5 c4 valid", 32'(valid5), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
